seg7_scan_driver: RTL and testbench

- Downstream consumer of the millisecond counter's BCD outputs (Units, Tens).
- Drives a two-digit, common-anode, multiplexed seven-segment display.
- Captures both digits atomically once per scan frame, so a count change mid-frame cannot tear the display.
- Decodes BCD to segments, inserts anti-ghosting guard gaps between digit slots, and optionally blanks a leading zero.

---
 rtl/seg7_scan_driver_pkg.sv | 30 +++
 rtl/seg7_scan_driver_if.sv | 22 ++
 rtl/seg7_scan_driver_bcd_to_7seg.sv | 27 ++
 rtl/seg7_scan_driver.sv | 113 +++++++++++
 tb/tb_seg7_scan_driver.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and constants for the two-digit
// multiplexed seven-segment scan driver.
package seg7_scan_driver_pkg;

  typedef enum logic [1:0] {
    GAP_U = 2'd0,
    UNITS = 2'd1,
    GAP_T = 2'd2,
    TENS  = 2'd3
  } scan_state_t;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit-in / display-out bundle for the scan driver.
// master drives the digits, slave drives the display.
interface seg7_scan_driver_if;
  import seg7_scan_driver_pkg::*;

  logic [3:0] units;
  logic [3:0] tens;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  modport master (
    output units, tens,
    input  seg, an, frame_tick
  );

  modport slave (
    input  units, tens,
    output seg, an, frame_tick
  );

endinterface

// File: rtl/seg7_scan_driver_bcd_to_7seg.sv
// Combinational BCD to active-high segment decoder.
// Non-BCD codes show a dash.
module bcd_to_7seg
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit common-anode scan driver with per-frame
// atomic digit capture, guard gaps and lead-zero blank.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV     = 50000,
  parameter int GUARD           = 16,
  parameter int BLANK_LEAD_ZERO = 1,
  parameter int ACTIVE_LOW_SEG  = 1
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic [3:0] Units,
  input  logic [3:0] Tens,
  output logic [6:0] Seg,
  output logic [1:0] An,
  output logic       Frame_tick
);

  localparam int MAXL =
    (REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD;
  localparam int CW = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam logic [CW-1:0] SLOT_END = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GUARD - 1);
  localparam logic [6:0] SEG_RST =
    (ACTIVE_LOW_SEG != 0) ? ~SEG_OFF : SEG_OFF;

  if (REFRESH_DIV < 2 || GUARD < 1) begin : g_bad_param
    $error("seg7_scan_driver: REFRESH_DIV>=2, GUARD>=1");
  end

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    u_q, t_q;
  logic          capture, last, blank_t;
  logic [3:0]    digit;
  logic [6:0]    dec_seg, raw_d, seg_d;
  logic [1:0]    an_d;

  assign capture = (state_q == GAP_U) && (cnt_q == '0);
  assign blank_t = (BLANK_LEAD_ZERO != 0) && (t_q == 4'd0);
  assign digit   = (state_q == TENS) ? t_q : u_q;

  bcd_to_7seg u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    last    = 1'b0;
    unique case (state_q)
      GAP_U, GAP_T: last = (cnt_q == GAP_END);
      UNITS, TENS:  last = (cnt_q == SLOT_END);
      default:      last = 1'b1;
    endcase
    if (last) begin
      cnt_d = '0;
      unique case (state_q)
        GAP_U:   state_d = UNITS;
        UNITS:   state_d = GAP_T;
        GAP_T:   state_d = TENS;
        TENS:    state_d = GAP_U;
        default: state_d = GAP_U;
      endcase
    end
  end

  // Display drive follows the current state one cycle later
  always_comb begin
    an_d  = AN_OFF;
    raw_d = SEG_OFF;
    unique case (1'b1)
      (state_q == UNITS): begin
        an_d  = AN_UNITS;
        raw_d = dec_seg;
      end
      (state_q == TENS) && !blank_t: begin
        an_d  = AN_TENS;
        raw_d = dec_seg;
      end
      default: begin
        an_d  = AN_OFF;
        raw_d = SEG_OFF;
      end
    endcase
    seg_d = (ACTIVE_LOW_SEG != 0) ? ~raw_d : raw_d;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= GAP_U;
      cnt_q      <= '0;
      u_q        <= 4'd0;
      t_q        <= 4'd0;
      An         <= AN_OFF;
      Seg        <= SEG_RST;
      Frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      An         <= an_d;
      Seg        <= seg_d;
      Frame_tick <= capture;
      if (capture) begin
        u_q <= Units;
        t_q <= Tens;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: two short-frame
// instances in lockstep plus one long-frame instance.
module tb_seg7_scan_driver;

  localparam int G  = 2;
  localparam int R  = 4;
  localparam int FL = 2 * G + 2 * R;
  localparam int LG = 16;
  localparam int LR = 500;
  localparam int LFL = 2 * LG + 2 * LR;

  logic clk = 1'b0;
  logic rst_ab = 1'b0;
  logic rst_c = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if ifa ();
  seg7_scan_driver_if ifb ();
  seg7_scan_driver_if ifc ();

  seg7_scan_driver #(
    .REFRESH_DIV(R), .GUARD(G),
    .BLANK_LEAD_ZERO(1), .ACTIVE_LOW_SEG(1)
  ) dut_a (
    .CLK(clk), .Reset_n(rst_ab),
    .Units(ifa.units), .Tens(ifa.tens),
    .Seg(ifa.seg), .An(ifa.an),
    .Frame_tick(ifa.frame_tick)
  );

  seg7_scan_driver #(
    .REFRESH_DIV(R), .GUARD(G),
    .BLANK_LEAD_ZERO(0), .ACTIVE_LOW_SEG(0)
  ) dut_b (
    .CLK(clk), .Reset_n(rst_ab),
    .Units(ifb.units), .Tens(ifb.tens),
    .Seg(ifb.seg), .An(ifb.an),
    .Frame_tick(ifb.frame_tick)
  );

  seg7_scan_driver #(
    .REFRESH_DIV(LR), .GUARD(LG),
    .BLANK_LEAD_ZERO(1), .ACTIVE_LOW_SEG(1)
  ) dut_c (
    .CLK(clk), .Reset_n(rst_c),
    .Units(ifc.units), .Tens(ifc.tens),
    .Seg(ifc.seg), .An(ifc.an),
    .Frame_tick(ifc.frame_tick)
  );

  int checks = 0;
  int failures = 0;

  int ph = 0;
  logic [3:0] mu [2];
  logic [3:0] mt [2];
  logic [19:0] q [$];

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [9:0] model_out(
    input int p, input logic [3:0] u, input logic [3:0] t,
    input bit blz, input bit al);
    logic [1:0] an;
    logic [6:0] s;
    an = 2'b11;
    s  = 7'h00;
    if (p >= G && p < G + R) begin
      an = 2'b10;
      s  = dec(u);
    end else if (p >= 2 * G + R && !(blz && t == 4'd0)) begin
      an = 2'b01;
      s  = dec(t);
    end
    if (al) s = ~s;
    return {p == 0, an, s};
  endfunction

  task automatic set_in(input logic [3:0] u, input logic [3:0] t);
    ifa.units = u; ifa.tens = t;
    ifb.units = u; ifb.tens = t;
  endtask

  task automatic model_reset();
    ph = 0;
    mu[0] = 4'd0; mt[0] = 4'd0;
    mu[1] = 4'd0; mt[1] = 4'd0;
    q.delete();
  endtask

  // Advance the reference one clock and push its prediction
  task automatic tick_model();
    @(posedge clk);
    if (ph == 0) begin
      mu[0] = ifa.units; mt[0] = ifa.tens;
      mu[1] = ifb.units; mt[1] = ifb.tens;
    end
    q.push_back({model_out(ph, mu[0], mt[0], 1'b1, 1'b1),
                 model_out(ph, mu[1], mt[1], 1'b0, 1'b0)});
    ph = (ph + 1) % FL;
  endtask

  task automatic test_reset();
    logic [9:0] oa, ob, oc;
    set_in(4'd0, 4'd0);
    ifc.units = 4'd0; ifc.tens = 4'd0;
    rst_ab = 1'b0; rst_c = 1'b0;
    repeat (3) @(negedge clk);
    oa = {ifa.frame_tick, ifa.an, ifa.seg};
    ob = {ifb.frame_tick, ifb.an, ifb.seg};
    oc = {ifc.frame_tick, ifc.an, ifc.seg};
    checks++;
    if (oa !== {1'b0, 2'b11, 7'h7F}) begin
      failures++;
      $display("FAIL reset_a got=%h want=%h", oa, {1'b0, 2'b11, 7'h7F});
    end
    checks++;
    if (ob !== {1'b0, 2'b11, 7'h00}) begin
      failures++;
      $display("FAIL reset_b got=%h want=%h", ob, {1'b0, 2'b11, 7'h00});
    end
    checks++;
    if (oc !== {1'b0, 2'b11, 7'h7F}) begin
      failures++;
      $display("FAIL reset_c got=%h want=%h", oc, {1'b0, 2'b11, 7'h7F});
    end
  endtask

  task automatic test_scan();
    logic [19:0] e, o;
    set_in(4'd7, 4'd4);
    model_reset();
    @(negedge clk);
    rst_ab = 1'b1;
    for (int i = 0; i < 2 * FL; i++) begin
      tick_model();
      @(negedge clk);
      e = q.pop_front();
      o = {ifa.frame_tick, ifa.an, ifa.seg,
           ifb.frame_tick, ifb.an, ifb.seg};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL scan cyc=%0d got=%h want=%h", i, o, e);
      end
      if (i == 0) begin
        checks++;
        if (ifa.frame_tick !== 1'b1) begin
          failures++;
          $display("FAIL scan_first_tick got=%b want=1", ifa.frame_tick);
        end
      end
      if (i == 3) begin
        checks++;
        if (ifa.seg !== 7'h78) begin
          failures++;
          $display("FAIL scan_units_seg got=%h want=78", ifa.seg);
        end
      end
    end
  endtask

  task automatic test_tear();
    logic [19:0] e, o;
    set_in(4'd3, 4'd1);
    for (int i = 0; i < 3 * FL; i++) begin
      tick_model();
      @(negedge clk);
      e = q.pop_front();
      o = {ifa.frame_tick, ifa.an, ifa.seg,
           ifb.frame_tick, ifb.an, ifb.seg};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL tear cyc=%0d got=%h want=%h", i, o, e);
      end
      if (i == 3 || i == 9 || i == 14 || i == 20) begin
        checks++;
        if (ifa.seg !== (i == 3 ? 7'h30 : i == 9 ? 7'h79 :
                         i == 14 ? 7'h00 : 7'h24)) begin
          failures++;
          $display("FAIL tear_seg cyc=%0d got=%h", i, ifa.seg);
        end
      end
      if (i == 4) set_in(4'd8, 4'd2);
    end
  endtask

  task automatic test_lead_zero();
    logic [19:0] e, o;
    set_in(4'd5, 4'd0);
    for (int i = 0; i < FL; i++) begin
      tick_model();
      @(negedge clk);
      e = q.pop_front();
      o = {ifa.frame_tick, ifa.an, ifa.seg,
           ifb.frame_tick, ifb.an, ifb.seg};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL lead_zero cyc=%0d got=%h want=%h", i, o, e);
      end
      if (i == 9) begin
        checks++;
        if ({ifa.an, ifa.seg, ifb.an, ifb.seg} !==
            {2'b11, 7'h7F, 2'b01, 7'h3F}) begin
          failures++;
          $display("FAIL lead_zero_tens got=%b/%h %b/%h",
                   ifa.an, ifa.seg, ifb.an, ifb.seg);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [19:0] e, o;
    set_in(4'hA, 4'hF);
    for (int i = 0; i < FL; i++) begin
      tick_model();
      @(negedge clk);
      e = q.pop_front();
      o = {ifa.frame_tick, ifa.an, ifa.seg,
           ifb.frame_tick, ifb.an, ifb.seg};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL illegal cyc=%0d got=%h want=%h", i, o, e);
      end
      if (i == 3 || i == 9) begin
        checks++;
        if ({ifa.seg, ifb.seg} !== {7'h3F, 7'h40}) begin
          failures++;
          $display("FAIL illegal_dash cyc=%0d got=%h/%h want=3f/40",
                   i, ifa.seg, ifb.seg);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [19:0] e, o;
    logic [19:0] off;
    off = {1'b0, 2'b11, 7'h7F, 1'b0, 2'b11, 7'h00};
    set_in(4'd6, 4'd2);
    for (int i = 0; i < 10; i++) begin
      tick_model();
      @(negedge clk);
      e = q.pop_front();
      o = {ifa.frame_tick, ifa.an, ifa.seg,
           ifb.frame_tick, ifb.an, ifb.seg};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mid_pre cyc=%0d got=%h want=%h", i, o, e);
      end
    end
    #2 rst_ab = 1'b0;
    #1;
    o = {ifa.frame_tick, ifa.an, ifa.seg,
         ifb.frame_tick, ifb.an, ifb.seg};
    checks++;
    if (o !== off) begin
      failures++;
      $display("FAIL mid_async got=%h want=%h", o, off);
    end
    model_reset();
    repeat (2) @(negedge clk);
    set_in(4'd9, 4'd0);
    rst_ab = 1'b1;
    for (int i = 0; i < FL + 2; i++) begin
      tick_model();
      @(negedge clk);
      e = q.pop_front();
      o = {ifa.frame_tick, ifa.an, ifa.seg,
           ifb.frame_tick, ifb.an, ifb.seg};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mid_post cyc=%0d got=%h want=%h", i, o, e);
      end
    end
  endtask

  task automatic test_long_run();
    int tq [$];
    int cyc;
    int seen;
    int want;
    ifc.units = 4'd3; ifc.tens = 4'd0;
    for (int k = 0; k < 10; k++) tq.push_back(1 + k * LFL);
    @(negedge clk);
    rst_c = 1'b1;
    cyc = 0;
    seen = 0;
    while (seen < 10 && cyc < 11 * LFL) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (ifc.an === 2'b00) begin
        failures++;
        $display("FAIL long_an cyc=%0d got=00", cyc);
      end
      if (ifc.frame_tick === 1'b1) begin
        want = tq.pop_front();
        seen++;
        checks++;
        if (cyc !== want) begin
          failures++;
          $display("FAIL long_tick n=%0d got=%0d want=%0d",
                   seen, cyc, want);
        end
      end
    end
    checks++;
    if (seen != 10) begin
      failures++;
      $display("FAIL long_count got=%0d want=10", seen);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear();
    test_lead_zero();
    test_illegal();
    test_mid_reset();
    test_long_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
